mesi_dir_arbiter: RTL and testbench

- Per-line directory controller for the write-invalidate MESI protocol, sitting between NUM_CORES per-core line FSMs and L2.
- Serialises read-fill and upgrade requests with round-robin arbitration.
- Broadcasts invalidations to the current sharers and owner, collects acks, then grants the requester.
- Drives the remote_inval and grant_exclusive inputs of each core's line FSM.

---
 rtl/mesi_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/mesi_dir_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mesi_dir_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_pkg.sv
// Shared types for the MESI directory: line states, directory FSM states
// and the kind of request being serviced.
package mesi_pkg;

  typedef enum logic [1:0] {
    LINE_I,
    LINE_S,
    LINE_E,
    LINE_M
  } line_state_e;

  typedef enum logic [1:0] {
    IDLE,
    INVAL,
    WAIT_ACK,
    GRANT
  } dir_state_e;

  typedef enum logic {
    RD,
    UPG
  } req_kind_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at
// ptr and returns the first requester as a one-hot winner.
module rr_arbiter
  import mesi_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDW       = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDW-1:0]       ptr,
  output logic [NUM_CORES-1:0] gnt,
  output logic                 valid
);

  logic [IDW-1:0] idx;

  // Walk the cores from ptr upward with wrap-around; first hit wins
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_CORES);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesi_dir_arbiter.sv
// Per-line MESI directory controller: arbitrates read-fill and upgrade
// requests, invalidates sharers/owner, collects acks and grants the winner.
module mesi_dir_arbiter
  import mesi_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int IDW         = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] rd_req,
  input  logic [NUM_CORES-1:0] upg_req,
  input  logic [NUM_CORES-1:0] inval_ack,
  input  logic [NUM_CORES-1:0] wb_valid,
  output logic [NUM_CORES-1:0] remote_inval,
  output logic [NUM_CORES-1:0] grant_exclusive,
  output logic [NUM_CORES-1:0] rd_grant,
  output logic                 l2_wb_strobe,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [NUM_CORES-1:0] sharers,
  output logic                 owner_valid,
  output logic [IDW-1:0]       owner_id
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

  dir_state_e           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, win_q, arb_idx;
  req_kind_e            kind_q, arb_kind, grant_kind;
  logic [NUM_CORES-1:0] pending_q, pending_d, targets_q;
  logic [NUM_CORES-1:0] eff_req, arb_oh, arb_targets, owner_oh, acc_ack, grant_oh;
  logic                 arb_valid, timeout_hit;
  logic [TW-1:0]        timer_q;

  assign eff_req = rd_req | upg_req;
  assign acc_ack = inval_ack & pending_q;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES),
    .IDW      (IDW)
  ) u_arb (
    .req  (eff_req),
    .ptr  (rr_ptr_q),
    .gnt  (arb_oh),
    .valid(arb_valid)
  );

  // Decode the winner and work out whom it must invalidate; a core raising both requests is an upgrade
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (arb_oh[i]) arb_idx = IDW'(i);
    end
    arb_kind    = upg_req[arb_idx] ? UPG : RD;
    owner_oh    = (owner_valid && owner_id != arb_idx) ? (ONE << owner_id) : '0;
    arb_targets = (arb_kind == UPG) ? ((sharers & ~arb_oh) | owner_oh) : owner_oh;
  end

  // Grant goes to the fresh winner on a direct IDLE->GRANT, else to the latched one
  always_comb begin
    grant_oh   = (state_q == IDLE) ? arb_oh : (ONE << win_q);
    grant_kind = (state_q == IDLE) ? arb_kind : kind_q;
  end

  // Next-state logic; acks are honoured in INVAL as well as WAIT_ACK
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          if (arb_targets == '0) begin
            state_d = GRANT;
          end else begin
            pending_d = arb_targets;
            state_d   = INVAL;
          end
        end
      end
      INVAL: begin
        pending_d = pending_q & ~inval_ack;
        state_d   = (pending_d == '0) ? GRANT : WAIT_ACK;
      end
      WAIT_ACK: begin
        pending_d = pending_q & ~inval_ack;
        if (pending_d == '0) begin
          state_d = GRANT;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          pending_d   = '0;
          timeout_hit = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, pending mask, ack timer, latched winner and rr pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      timer_q   <= '0;
      win_q     <= '0;
      kind_q    <= RD;
      targets_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (state_q == WAIT_ACK) begin
        timer_q <= timer_q + 1'b1;
      end else if (state_q == GRANT) begin
        timer_q <= '0;
      end
      if (state_q == IDLE && arb_valid) begin
        win_q     <= arb_idx;
        kind_q    <= arb_kind;
        targets_q <= arb_targets;
      end
      if (state_q == GRANT) begin
        rr_ptr_q <= (win_q == IDW'(NUM_CORES - 1)) ? '0 : win_q + 1'b1;
      end
    end
  end

  // Registered pulse and status outputs, computed from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remote_inval    <= '0;
      grant_exclusive <= '0;
      rd_grant        <= '0;
      l2_wb_strobe    <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      remote_inval    <= (state_d == INVAL) ? pending_d : '0;
      grant_exclusive <= (state_d == GRANT && grant_kind == UPG) ? grant_oh : '0;
      rd_grant        <= (state_d == GRANT && grant_kind == RD) ? grant_oh : '0;
      l2_wb_strobe    <= (state_q == INVAL || state_q == WAIT_ACK) && |(acc_ack & wb_valid);
      busy            <= (state_d != IDLE);
      timeout_err     <= timeout_err | timeout_hit;
    end
  end

  // Directory update as the grant is issued: targets drop out, winner joins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sharers     <= '0;
      owner_valid <= 1'b0;
      owner_id    <= '0;
    end else if (state_q == GRANT) begin
      sharers <= (sharers & ~targets_q) | (ONE << win_q);
      if (kind_q == UPG) begin
        owner_valid <= 1'b1;
        owner_id    <= win_q;
      end else if (owner_valid && targets_q[owner_id]) begin
        owner_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mesi_dir_arbiter.sv
// Scoreboard bench for mesi_dir_arbiter: directed scenarios push expected
// output events (with their cycle) and a monitor pops and compares them.
module tb_mesi_dir_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] rd_req, upg_req, manual_ack, wb_valid, inval_ack;
  logic         auto_ack;
  logic [N-1:0] remote_inval, grant_exclusive, rd_grant, sharers;
  logic         l2_wb_strobe, busy, timeout_err, owner_valid;
  logic [1:0]   owner_id;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t;

  typedef struct {
    int           cyc;
    logic [N-1:0] inv;
    logic [N-1:0] gx;
    logic [N-1:0] rg;
    logic         wb;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  mesi_dir_arbiter #(
    .NUM_CORES  (N),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_req         (rd_req),
    .upg_req        (upg_req),
    .inval_ack      (inval_ack),
    .wb_valid       (wb_valid),
    .remote_inval   (remote_inval),
    .grant_exclusive(grant_exclusive),
    .rd_grant       (rd_grant),
    .l2_wb_strobe   (l2_wb_strobe),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .sharers        (sharers),
    .owner_valid    (owner_valid),
    .owner_id       (owner_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // auto_ack makes every targeted core answer within its INVAL cycle
  assign inval_ack = manual_ack | (auto_ack ? remote_inval : '0);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] upg);
    rd_req  = rd;
    upg_req = upg;
  endtask

  task automatic setAck(input logic [N-1:0] ack, input logic [N-1:0] wb);
    manual_ack = ack;
    wb_valid   = wb;
  endtask

  task automatic expectEv(input int c, input logic [N-1:0] inv, input logic [N-1:0] gx,
                          input logic [N-1:0] rg, input logic wb);
    ev_t e;
    e.cyc = c;
    e.inv = inv;
    e.gx  = gx;
    e.rg  = rg;
    e.wb  = wb;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_remote_inval"}, 32'(remote_inval), 32'h0);
    checkOutput({tag, "_grant_excl"}, 32'(grant_exclusive), 32'h0);
    checkOutput({tag, "_rd_grant"}, 32'(rd_grant), 32'h0);
    checkOutput({tag, "_wb_strobe"}, 32'(l2_wb_strobe), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    checkOutput({tag, "_sharers"}, 32'(sharers), 32'h0);
    checkOutput({tag, "_owner_valid"}, 32'(owner_valid), 32'h0);
    checkOutput({tag, "_owner_id"}, 32'(owner_id), 32'h0);
  endtask

  task automatic checkDir(input string tag, input logic [N-1:0] sh, input logic ov, input logic [1:0] oid);
    checkOutput({tag, "_sharers"}, 32'(sharers), 32'(sh));
    checkOutput({tag, "_owner_valid"}, 32'(owner_valid), 32'(ov));
    if (ov) checkOutput({tag, "_owner_id"}, 32'(owner_id), 32'(oid));
  endtask

  // Monitor: every cycle with any pulse output must match the next expected event
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (|remote_inval || |grant_exclusive || |rd_grant || l2_wb_strobe)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_event cyc=%0d inv=%b gx=%b rg=%b wb=%b required no event",
                   cyc, remote_inval, grant_exclusive, rd_grant, l2_wb_strobe);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.inv !== remote_inval || mon_e.gx !== grant_exclusive ||
              mon_e.rg !== rd_grant || mon_e.wb !== l2_wb_strobe) begin
            errors++;
            $display("[TB] FAIL event actual cyc=%0d inv=%b gx=%b rg=%b wb=%b required cyc=%0d inv=%b gx=%b rg=%b wb=%b",
                     cyc, remote_inval, grant_exclusive, rd_grant, l2_wb_strobe,
                     mon_e.cyc, mon_e.inv, mon_e.gx, mon_e.rg, mon_e.wb);
          end
        end
      end
    end
  end

  // Global guard so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus('0, '0);
    setAck('0, '0);
    auto_ack = 1'b0;
    rst_n = 1'b0;
    tick(2);
    checkAllZero("reset");
    rst_n = 1'b1;
    tick(1);

    $display("[TB] cold upgrade by core 0");
    t = cyc;
    applyStimulus(4'b0000, 4'b0001);
    expectEv(t + 1, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    waitUntil(t + 1);
    checkOutput("cold_busy", 32'(busy), 32'h1);
    waitUntil(t + 2);
    applyStimulus('0, '0);
    checkDir("cold", 4'b0001, 1'b1, 2'd0);

    $display("[TB] read by current owner");
    t = cyc;
    applyStimulus(4'b0001, 4'b0000);
    expectEv(t + 1, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    waitUntil(t + 2);
    applyStimulus('0, '0);
    checkDir("ownrd", 4'b0001, 1'b1, 2'd0);

    $display("[TB] read by core 1 against owner 0 with writeback");
    t = cyc;
    applyStimulus(4'b0010, 4'b0000);
    expectEv(t + 1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 3, 4'b0000, 4'b0000, 4'b0010, 1'b1);
    waitUntil(t + 2);
    setAck(4'b0001, 4'b0001);
    waitUntil(t + 3);
    setAck('0, '0);
    waitUntil(t + 4);
    applyStimulus('0, '0);
    checkDir("rd1", 4'b0010, 1'b0, 2'd0);

    $display("[TB] build sharer set 0111");
    t = cyc;
    applyStimulus(4'b0001, 4'b0000);
    expectEv(t + 1, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    waitUntil(t + 2);
    applyStimulus('0, '0);
    t = cyc;
    applyStimulus(4'b0100, 4'b0000);
    expectEv(t + 1, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    waitUntil(t + 2);
    applyStimulus('0, '0);
    checkDir("share", 4'b0111, 1'b0, 2'd0);

    $display("[TB] upgrade by core 1 with sharers");
    t = cyc;
    applyStimulus(4'b0000, 4'b0010);
    expectEv(t + 1, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 5, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    waitUntil(t + 2);
    setAck(4'b0001, 4'b0000);
    waitUntil(t + 3);
    setAck(4'b1000, 4'b1000);
    waitUntil(t + 4);
    setAck(4'b0100, 4'b0000);
    waitUntil(t + 5);
    setAck('0, '0);
    checkOutput("upg_busy_grant", 32'(busy), 32'h1);
    waitUntil(t + 6);
    applyStimulus('0, '0);
    checkDir("upg1", 4'b0010, 1'b1, 2'd1);

    $display("[TB] upgrade by core 2 (rd+upg), ack inside INVAL");
    t = cyc;
    applyStimulus(4'b0100, 4'b0100);
    expectEv(t + 1, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 2, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    waitUntil(t + 1);
    setAck(4'b0010, 4'b0000);
    waitUntil(t + 2);
    setAck('0, '0);
    waitUntil(t + 3);
    applyStimulus('0, '0);
    checkDir("upg2", 4'b0100, 1'b1, 2'd2);

    $display("[TB] read by core 0 against dirty owner 2");
    t = cyc;
    applyStimulus(4'b0001, 4'b0000);
    expectEv(t + 1, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 3, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    waitUntil(t + 2);
    setAck(4'b0100, 4'b0100);
    waitUntil(t + 3);
    setAck('0, '0);
    waitUntil(t + 4);
    applyStimulus('0, '0);
    checkDir("dirty", 4'b0001, 1'b0, 2'd0);

    $display("[TB] reset between scenarios");
    tick(1);
    rst_n = 1'b0;
    #1;
    checkAllZero("reset2");
    tick(1);
    rst_n = 1'b1;
    tick(1);

    $display("[TB] fairness with all cores upgrading");
    auto_ack = 1'b1;
    t = cyc;
    applyStimulus(4'b0000, 4'b1111);
    expectEv(t + 1,  4'b0000, 4'b0001, 4'b0000, 1'b0);
    expectEv(t + 3,  4'b0001, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 4,  4'b0000, 4'b0010, 4'b0000, 1'b0);
    expectEv(t + 6,  4'b0010, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 7,  4'b0000, 4'b0100, 4'b0000, 1'b0);
    expectEv(t + 9,  4'b0100, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 10, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    expectEv(t + 12, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 13, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    waitUntil(t + 14);
    applyStimulus('0, '0);
    auto_ack = 1'b0;
    checkDir("fair", 4'b0001, 1'b1, 2'd0);

    $display("[TB] ack timeout on upgrade by core 3");
    t = cyc;
    applyStimulus(4'b0000, 4'b1000);
    expectEv(t + 1,  4'b0001, 4'b0000, 4'b0000, 1'b0);
    expectEv(t + 10, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    waitUntil(t + 9);
    checkOutput("timeout_err_before", 32'(timeout_err), 32'h0);
    waitUntil(t + 10);
    checkOutput("timeout_err_set", 32'(timeout_err), 32'h1);
    waitUntil(t + 11);
    applyStimulus('0, '0);
    waitUntil(t + 15);
    checkOutput("timeout_err_sticky", 32'(timeout_err), 32'h1);
    checkOutput("timeout_idle_busy", 32'(busy), 32'h0);
    checkDir("tmo", 4'b1000, 1'b1, 2'd3);

    $display("[TB] reset in WAIT_ACK");
    t = cyc;
    applyStimulus(4'b0000, 4'b0010);
    expectEv(t + 1, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    waitUntil(t + 3);
    checkOutput("midrst_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    applyStimulus('0, '0);
    #1;
    checkAllZero("midrst");
    waitUntil(t + 5);
    rst_n = 1'b1;
    waitUntil(t + 18);
    checkOutput("midrst_busy_post", 32'(busy), 32'h0);

    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
